simplez_tx_port: RTL
====================

SIMPLEZ_TX_PORT -- requirements
Module: simplez_tx_port

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 104, meaning clk cycles per serial bit (legal range 2..4095).
REQ-002 The block SHALL have parameter STATUS_ADDR, default 9'd508, meaning the bus address of the status word.
REQ-003 The block SHALL have parameter DATA_ADDR, default 9'd509, meaning the bus address of the transmit data word.
REQ-004 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port addr  input  9  Simplez bus address.
REQ-007 The block SHALL have port wr  input  1  bus write strobe, one cycle per write.
REQ-008 The block SHALL have port rd  input  1  bus read strobe, one cycle per read.
REQ-009 The block SHALL have port data_in  input  12  bus write data.
REQ-010 The block SHALL have port data_out  output  12  registered read data.
REQ-011 The block SHALL have port cs  output  1  combinational, high when addr equals STATUS_ADDR or DATA_ADDR.
REQ-012 The block SHALL have port tx  output  1  registered serial line, idle high.
REQ-013 The block SHALL have port busy  output  1  registered, high while a frame is in progress.

Function
REQ-014 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly BAUD_DIV cycles, 10*BAUD_DIV cycles per frame.
REQ-015 State machine SHALL have states IDLE, START, DATA, STOP; IDLE->START on accepted write; START->DATA after BAUD_DIV cycles; DATA->STOP after 8th bit completes; STOP->IDLE after BAUD_DIV cycles.
REQ-016 A write (wr=1, addr=DATA_ADDR) sampled while busy=0 SHALL be accepted: data_in[7:0] latched into shift register and last_byte, baud counter cleared, tx=0 and busy=1 from that same edge.
REQ-017 Baud counter SHALL count 0..BAUD_DIV-1 and wrap; bit advance occurs on the wrap; data_in[11:8] SHALL be ignored.
REQ-018 busy SHALL fall on the edge ending the stop bit; a write sampled on that same edge SHALL be accepted (IDLE-equivalent), giving back-to-back frames with no idle gap.
REQ-019 A write to DATA_ADDR sampled while busy=1 (other than REQ-018 edge) SHALL be discarded and SHALL set sticky flag overrun.
REQ-020 A read (rd=1) SHALL load data_out on the sampling edge: STATUS_ADDR -> {10'b0, overrun, ~busy}; DATA_ADDR -> {4'b0, last_byte}; any other address -> 12'h000; data_out SHALL hold until the next read.
REQ-021 A status read SHALL clear overrun after capturing it; if an overrun-setting write and a status read occur on the same edge, data_out SHALL show the old overrun value and overrun SHALL end set.
REQ-022 Writes to STATUS_ADDR or unmapped addresses SHALL have no effect; rd and wr both high on one edge SHALL perform both actions.
REQ-023 cs SHALL depend on addr only, not on rd/wr.

Reset
REQ-024 With rstn=0 sampled on an edge: state=IDLE, tx=1, busy=0, overrun=0, shift register=0, last_byte=0, baud counter=0, data_out=12'h000.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 after that edge); no partial stop bit is emitted.
REQ-026 Bus strobes sampled while rstn=0 SHALL be ignored.

Verification (bench BAUD_DIV=4)
REQ-027 Reset, then status read -> tx=1, busy=0, data_out=12'h001.
REQ-028 Write 12'h1A5 to 509 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high exactly 40 cycles; read 509 returns 12'h0A5.
REQ-029 Write 12'h033 then write 12'h0FF at cycle 10 -> line carries only 0x33; status read returns 12'h002; next status read after frame returns 12'h001.
REQ-030 Write 12'h0C3, second write 12'h03C on the edge busy falls -> second start bit immediately follows first stop bit, no gap, no overrun.
REQ-031 Write 12'h0FF, assert rstn=0 for 1 cycle during data bit 3 -> tx=1 and busy=0 after that edge; status read returns 12'h001.
REQ-032 Write 12'h055 to addr 9'h100 -> cs=0, tx stays 1, busy stays 0; read 9'h100 returns 12'h000.

Source files
------------

// File: rtl/simplez_tx_port.sv
// Simplez memory-mapped UART transmitter: 8N1 framing, status word with
// ~busy / sticky overrun bits, and readback of the last byte accepted.
module simplez_tx_port #(
  parameter int         BAUD_DIV    = 104,
  parameter logic [8:0] STATUS_ADDR = 9'd508,
  parameter logic [8:0] DATA_ADDR   = 9'd509
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [11:0] data_in,
  output logic [11:0] data_out,
  output logic        cs,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  last_byte;
  logic        overrun;
  logic        tx_nx, busy_nx;
  logic        wrap, wr_data, accept, set_ovr;

  assign cs      = (addr == STATUS_ADDR) || (addr == DATA_ADDR);
  assign wrap    = (baud_cnt == 12'(BAUD_DIV - 1));
  assign wr_data = wr && (addr == DATA_ADDR);
  // The stop-bit wrap edge counts as idle so back-to-back frames have no gap.
  assign accept  = wr_data && ((state == IDLE) || ((state == STOP) && wrap));
  assign set_ovr = wr_data && !accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: every bit transition happens on the baud wrap
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = START;
      START: if (wrap) state_nx = DATA;
      DATA:  if (wrap && (bit_cnt == 3'd7)) state_nx = STOP;
      STOP:  if (accept) state_nx = START;
             else if (wrap) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next value of the registered line and busy flag
  always_comb begin
    busy_nx = (state_nx != IDLE);
    tx_nx   = tx;
    if (accept) tx_nx = 1'b0;
    else begin
      case (state)
        START:   if (wrap) tx_nx = shreg[0];
        DATA:    if (wrap) tx_nx = (bit_cnt == 3'd7) ? 1'b1 : shreg[0];
        STOP:    if (wrap) tx_nx = 1'b1;
        default: tx_nx = 1'b1;
      endcase
    end
  end

  // Transmit datapath: baud counter, bit counter, shift register, line
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      last_byte <= '0;
    end else begin
      tx   <= tx_nx;
      busy <= busy_nx;
      if (accept) begin
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        shreg     <= data_in[7:0];
        last_byte <= data_in[7:0];
      end else if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (wrap) begin
        baud_cnt <= '0;
        // Shift as each data bit is put on the line so shreg[0] is always next.
        if (state == START) begin
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end else if (state == DATA && bit_cnt != 3'd7) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 12'd1;
      end
    end
  end

  // Bus read capture and sticky overrun (set wins over read-clear)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      if (rd) begin
        if (addr == STATUS_ADDR)    data_out <= {10'b0, overrun, ~busy};
        else if (addr == DATA_ADDR) data_out <= {4'b0, last_byte};
        else                        data_out <= 12'h000;
      end
      if (set_ovr)                           overrun <= 1'b1;
      else if (rd && (addr == STATUS_ADDR))  overrun <= 1'b0;
    end
  end

endmodule
